// File: rtl/bilbo_uart_pkg.sv
// Shared UART constants for the bilbo board: bit timing and receiver FSM state encoding.
package bilbo_uart_pkg;

    // 50 MHz / 115200 baud, rounded; also used by the transmit-side bit-clock divider.
    localparam int unsigned CLKS_PER_BIT_115200 = 434;

    typedef logic [2:0] uart_rx_state_t;

    localparam uart_rx_state_t StIdle  = 3'd0;
    localparam uart_rx_state_t StStart = 3'd1;
    localparam uart_rx_state_t StData  = 3'd2;
    localparam uart_rx_state_t StStop  = 3'd3;
    localparam uart_rx_state_t StBreak = 3'd4;

endpackage

// File: rtl/bilbo_uart_rx_if.sv
// Byte stream from the UART receiver to the core, plus its error pulses.
interface bilbo_uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;

    // Receiver side.
    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        input  rx_ready
    );

    // Consumer side.
    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        output rx_ready
    );

endinterface

// File: rtl/bilbo_sync_fifo.sv
// Small synchronous FIFO with a registered head word; push and pop may coincide, even when full.
module bilbo_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic             full_o,
    output logic             empty_o,
    output logic [WIDTH-1:0] head_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  rd_ptr_nxt;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CntW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = head_q;

    assign do_pop     = pop_i & ~empty_o;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push    = push_i & (~full_o | do_pop);
    assign rd_ptr_nxt = rd_ptr_q + PtrW'(1);

    // Pointer, occupancy and head-word next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_nxt;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // Head only moves on pop or on push into an empty FIFO.
        if (do_pop) begin
            if (count_q > CntW'(1)) begin
                head_d = mem_q[rd_ptr_nxt];
            end else if (do_push) begin
                head_d = wdata_i;
            end
        end else if (do_push && empty_o) begin
            head_d = wdata_i;
        end
    end

    // Control state registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge CLOCK_50) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/bilbo_uart_rx.sv
// 8N1 UART receiver: synchronises the line, samples at bit centres and queues bytes in a FIFO.
module bilbo_uart_rx
    import bilbo_uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_115200,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   rx_i,
    bilbo_uart_rx_if.master        bus
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

    logic           rx_meta_q, rx_s_q;
    uart_rx_state_t state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     shift_q, shift_d;
    logic           frame_err_q, frame_err_d;
    logic           overrun_q, overrun_d;
    logic           push_req;
    logic           fifo_full, fifo_empty, pop;
    logic [7:0]     fifo_head;

    assign pop           = ~fifo_empty & bus.rx_ready;
    assign bus.rx_valid  = ~fifo_empty;
    assign bus.rx_data   = fifo_head;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;

    // Two-flop synchroniser, preset to the idle-high line level.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx_i;
            rx_s_q    <= rx_meta_q;
        end
    end

    // Frame FSM: start qualification at half a bit, then one sample per bit period.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        push_req    = 1'b0;
        case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    cnt_d   = '0;
                end
            end
            StStart: begin
                if (cnt_q == HalfLast) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    // A start bit gone high by mid-bit is treated as a glitch.
                    state_d = rx_s_q ? StIdle : StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (cnt_q == BitLast) begin
                    cnt_d   = '0;
                    shift_d = {rx_s_q, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (cnt_q == BitLast) begin
                    cnt_d = '0;
                    if (rx_s_q) begin
                        push_req = 1'b1;
                        // Re-arm at stop-bit centre so back-to-back frames are caught.
                        state_d  = StIdle;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StBreak;
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StBreak: begin
                if (rx_s_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        overrun_d = push_req & fifo_full & ~pop;
    end

    // FSM, datapath and error-pulse registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    bilbo_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .push_i   (push_req),
        .wdata_i  (shift_q),
        .pop_i    (pop),
        .full_o   (fifo_full),
        .empty_o  (fifo_empty),
        .head_o   (fifo_head)
    );

endmodule
